// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master picorv32 memory-bus arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [1:0] owner_onehot(input owner_t o);
    return (o == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Slave-response watchdog: counts stalled BUSY cycles, fires on the limit
// cycle and keeps a sticky timeout flag until reset.
module mem_arb_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic active,
  input  logic s_ready,
  output logic fire,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;
  logic             flag;

  // cnt holds the number of stalled cycles already spent, so the limit
  // cycle is the one where cnt equals TIMEOUT_CYC-1.
  assign fire    = active && !s_ready && (cnt == LAST);
  assign timeout = flag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if (active && !s_ready && (cnt != SAT)) begin
        cnt <= cnt + 1'b1;
      end
      if (fire) begin
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the picorv32 native memory bus.
// Optional slave watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout
);

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  owner_t      winner;
  logic [1:0]  grant_q;
  logic        any_req;
  logic        own_valid;
  logic        own_ready;
  logic        fire;
  logic [DATA_W-1:0] resp_data;

  assign any_req = m0_valid | m1_valid;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    winner = OWN_M0;
    if (m0_valid && m1_valid) begin
      winner = (last_grant == OWN_M0) ? OWN_M1 : OWN_M0;
    end else if (m1_valid) begin
      winner = OWN_M1;
    end
  end

  assign own_valid = (state == BUSY) && ((owner == OWN_M1) ? m1_valid : m0_valid);
  assign own_ready = own_valid && (s_ready || fire);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= OWN_M0;
      last_grant <= OWN_M1;
      grant_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            owner      <= winner;
            last_grant <= winner;
            grant_q    <= owner_onehot(winner);
          end
        end
        BUSY: begin
          // Completion, timeout and owner abort all return through IDLE.
          if (!own_valid || own_ready) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign s_valid = own_valid && !fire;
  assign s_addr  = (owner == OWN_M1) ? m1_addr  : m0_addr;
  assign s_wdata = (owner == OWN_M1) ? m1_wdata : m0_wdata;
  assign s_wstrb = (owner == OWN_M1) ? m1_wstrb : m0_wstrb;

  assign resp_data = fire ? ERR_DATA : s_rdata;
  assign m0_ready  = own_ready && (owner == OWN_M0);
  assign m1_ready  = own_ready && (owner == OWN_M1);
  assign m0_rdata  = m0_ready ? resp_data : '0;
  assign m1_rdata  = m1_ready ? resp_data : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic start;
  assign start = (state == IDLE) && any_req;

  mem_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .active  (own_valid),
    .s_ready (s_ready),
    .fire    (fire),
    .timeout (timeout)
  );
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYC;
  assign fire       = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        vld [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(vld[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(vld[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), who won last, how many
  // stalled cycles the current transfer has spent, and the sticky flag.
  int   cur = -1;
  int   last = 1;
  int   bcnt = 0;
  bit   tflag = 1'b0;
  bit [1:0] done = 2'b00;

  logic [1:0]  e_grant, e_rdy;
  logic        e_sval, ov, fire;
  logic [31:0] e_rd0, e_rd1;

  always_comb begin
    e_grant = 2'b00; e_sval = 1'b0; e_rdy = 2'b00;
    e_rd0 = '0; e_rd1 = '0; ov = 1'b0; fire = 1'b0;
    if (cur == 0 || cur == 1) begin
      e_grant = (cur == 0) ? 2'b01 : 2'b10;
      ov      = vld[cur];
      fire    = TO_EN && ov && !s_ready && (bcnt == TO_CYC - 1);
      e_sval  = ov && !fire;
      if (ov && (s_ready || fire)) begin
        e_rdy = e_grant;
        if (cur == 0) e_rd0 = s_ready ? s_rdata : ERR;
        else          e_rd1 = s_ready ? s_rdata : ERR;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur = -1; last = 1; bcnt = 0; tflag = 1'b0; done = 2'b00;
    end else begin
      done = e_rdy;
      if (cur < 0) begin
        if (vld[0] || vld[1]) begin
          cur  = (vld[0] && vld[1]) ? 1 - last : (vld[0] ? 0 : 1);
          last = cur;
          bcnt = 0;
        end
      end else if (!ov || e_rdy != 2'b00) begin
        if (fire) tflag = 1'b1;
        cur = -1;
      end else begin
        bcnt++;
      end
    end
  end

  // Single compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant",    grant,    e_grant);
      chk("s_valid",  s_valid,  e_sval);
      chk("m0_ready", m0_ready, e_rdy[0]);
      chk("m1_ready", m1_ready, e_rdy[1]);
      chk("m0_rdata", m0_rdata, e_rd0);
      chk("m1_rdata", m1_rdata, e_rd1);
      chk("timeout",  timeout,  tflag);
      if (e_sval) begin
        chk("s_addr",  s_addr,  addr[cur]);
        chk("s_wdata", s_wdata, wdata[cur]);
        chk("s_wstrb", s_wstrb, wstrb[cur]);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      vld[m] = 1'b0; addr[m] = '0; wdata[m] = '0; wstrb[m] = '0;
    end
    s_ready = 1'b0;
  endtask

  task automatic do_reset();
    #1 resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic new_req(input int m);
    vld[m]   = 1'b1;
    addr[m]  = $urandom();
    wdata[m] = $urandom();
    wstrb[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  logic [1:0] gseq [8];
  int ng;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    idle_inputs();
    do_reset();
    #1 chk("rst_grant", grant, 2'b00);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk_on = 1'b1;

    // Single read from M0, slave answers in the second BUSY cycle.
    nxt(); vld[0] = 1'b1; addr[0] = 32'h0000_0040; wstrb[0] = 4'h0;
    #1 chk("rd_req_cycle_grant", grant, 2'b00);
    nxt(); #1 chk("rd_grant", grant, 2'b01);
    chk("rd_s_addr", s_addr, 32'h0000_0040);
    nxt(); s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1 chk("rd_m0_ready", m0_ready, 1'b1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_ready", m1_ready, 1'b0);
    nxt(); vld[0] = 1'b0; s_ready = 1'b0;
    #1 chk("rd_bubble_grant", grant, 2'b00);

    // Tie right after reset: M0 first, then strict alternation.
    do_reset();
    nxt(); new_req(0); new_req(1); s_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      nxt(); #1;
      if (grant != 2'b00) begin
        if (ng < 8) gseq[ng] = grant;
        ng++;
      end
    end
    vld[0] = 1'b0; vld[1] = 1'b0; s_ready = 1'b0;
    chk("tie_count", ng, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("tie_seq%0d", i), gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // Write passthrough from M1.
    nxt(); vld[1] = 1'b1; addr[1] = 32'h0000_0100; wdata[1] = 32'hA5A5_A5A5; wstrb[1] = 4'b0011;
    nxt(); #1 chk("wr_grant", grant, 2'b10);
    chk("wr_s_valid", s_valid, 1'b1);
    chk("wr_s_addr", s_addr, 32'h0000_0100);
    chk("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_s_wstrb", s_wstrb, 4'b0011);
    s_ready = 1'b1;
    #1 chk("wr_m1_ready", m1_ready, 1'b1);
    chk("wr_m0_ready", m0_ready, 1'b0);
    nxt(); vld[1] = 1'b0; s_ready = 1'b0;

    // Abort by M0 one cycle into BUSY; stray s_ready must be ignored.
    nxt(); vld[0] = 1'b1; addr[0] = 32'h0000_0200; wstrb[0] = 4'h0;
    nxt(); #1 chk("ab_grant", grant, 2'b01);
    nxt(); vld[0] = 1'b0; s_ready = 1'b1;
    #1 chk("ab_s_valid", s_valid, 1'b0);
    chk("ab_m0_ready", m0_ready, 1'b0);
    nxt(); s_ready = 1'b0;
    #1 chk("ab_idle_grant", grant, 2'b00);
    new_req(0); new_req(1);
    nxt(); #1 chk("ab_last_kept", grant, 2'b10);
    vld[0] = 1'b0; vld[1] = 1'b0;
    nxt();

    // Asynchronous reset in the middle of a transfer.
    nxt(); new_req(1);
    nxt(); #1 chk("rm_grant", grant, 2'b10);
    s_ready = 1'b1;
    #1 chk("rm_pre_ready", m1_ready, 1'b1);
    resetn = 1'b0;
    #1 chk("rm_grant0", grant, 2'b00);
    chk("rm_s_valid", s_valid, 1'b0);
    chk("rm_m0_ready", m0_ready, 1'b0);
    chk("rm_m1_ready", m1_ready, 1'b0);
    nxt(); vld[1] = 1'b0; s_ready = 1'b0; resetn = 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Slave never answers: error response on the 8th BUSY cycle.
    do_reset();
    nxt(); vld[0] = 1'b1; addr[0] = 32'h0000_0300;
    for (int k = 1; k <= TO_CYC; k++) begin
      nxt(); #1 chk($sformatf("to_ready%0d", k), m0_ready, k == TO_CYC);
      if (k == TO_CYC) begin
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_s_valid", s_valid, 1'b0);
      end
    end
    nxt(); vld[0] = 1'b0;
    #1 chk("to_idle", grant, 2'b00);
    chk("to_flag", timeout, 1'b1);
    repeat (3) nxt();
    chk("to_sticky", timeout, 1'b1);
    do_reset();
    #1 chk("to_cleared", timeout, 1'b0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      nxt();
      for (int m = 0; m < 2; m++) begin
        if (!vld[m]) begin
          if ($urandom_range(0, 2) == 0) new_req(m);
        end else if (done[m]) begin
          if ($urandom_range(0, 1) == 0) vld[m] = 1'b0;
          else new_req(m);
        end else if ($urandom_range(0, 39) == 0) begin
          vld[m] = 1'b0;
        end
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom();
    end
    nxt();
    idle_inputs();
    repeat (3) nxt();
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares one slave port, the system block RAM, between master 0 (picorv32 core) and master 1 (UART bootloader/DMA loader). Grants are round-robin, one outstanding transaction at a time. It sits between the masters and the SoC address decoder.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `wstrb` width is `DATA_W/8`
- `TIMEOUT_CYC`, 255, slave-response watchdog limit in cycles (used only with `MEM_ARB_TIMEOUT_EN`)
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `m0_valid`, `m1_valid`  in  1  master request
- `m0_addr`, `m1_addr`  in  ADDR_W  request address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_wstrb`, `m1_wstrb`  in  DATA_W/8  byte strobes; 0 means read
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse to the master
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, valid while the matching ready is high
- `s_valid`  out  1  request to the slave
- `s_addr`, `s_wdata`, `s_wstrb`  out  ADDR_W, DATA_W, DATA_W/8  muxed from the owner
- `s_ready`  in  1  slave completion
- `s_rdata`  in  DATA_W  slave read data
- `grant`  out  2  one-hot owner, 2'b00 when idle
- `timeout`  out  1  sticky watchdog flag

## Operation
- FSM states:
  - IDLE:
    - if any `mN_valid` is high, register the owner and go to BUSY.
    - if only one master requests, it wins.
    - if both request, the master other than `last_grant` wins.
    - `last_grant` updates on every grant.
  - BUSY:
    - `s_valid = owner_valid`.
    - `s_addr`/`s_wdata`/`s_wstrb` follow the owner's live inputs combinationally.
    - on `s_ready`: `owner_ready = 1` and `owner_rdata = s_rdata` in the same cycle, then go to IDLE.
- Owner drops `mN_valid` in BUSY before `s_ready` (abort): go to IDLE next cycle with no ready pulse. `last_grant` keeps its value.
- Non-owner master: ready = 0 and rdata = 0 at all times.
- `s_ready` while `s_valid` is low: ignored.
- Reset mid-transaction: everything returns to reset values immediately. Any in-flight slave access is abandoned.
- Reset values:
  - state IDLE, `last_grant` = master 1 (so master 0 wins the first tie)
  - `grant` 2'b00, `s_valid` 0, `m0_ready`/`m1_ready` 0, rdata outputs 0, `timeout` 0

## Timing
- Arbitration takes one registered cycle.
  - Request seen in cycle N (IDLE) gives `grant` and `s_valid` in cycle N+1.
- Ready is combinational from `s_ready`, with zero added latency.
- There is one mandatory IDLE bubble after each completion.
  - With a 1-cycle slave, a transaction takes 3 cycles from valid to the next possible grant.
- Alternation under continuous contention: grants M0, M1, M0, …, each separated by the IDLE cycle.
- A master holding `valid` stays pending; no request is dropped. Maximum wait is one foreign transaction.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - a counter clears on entry to BUSY and increments each BUSY cycle without `s_ready`.
  - When the count reaches `TIMEOUT_CYC`, that cycle forces `owner_ready = 1` and `owner_rdata = ERR_DATA`, and drops `s_valid`.
  - Next cycle the FSM is in IDLE and `timeout` sets (sticky until reset).
  - If `s_ready` arrives on the limit cycle, the normal completion wins and `timeout` stays 0.
- Undefined: no counter; BUSY waits indefinitely; `timeout` is tied 0.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (IDLE, BUSY)
  - owner encoding (OWN_M0, OWN_M1)
  - default `ERR_DATA` constant
- One sub-module `mem_arb_wdog`: the watchdog counter with compare and sticky flag. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Single read: M0 reads 0x0000_0040; slave answers after 2 cycles with 0x1234_5678. Expect `grant` = 01 one cycle after `m0_valid`, then `m0_ready` pulse with `m0_rdata` = 0x1234_5678, `m1_ready` = 0.
- Tie after reset: both valid in the same cycle. Expect M0 granted first, M1 next, strict alternation over 8 back-to-back transfers.
- Write passthrough: M1 writes 0xA5A5_A5A5 with `wstrb` 4'b0011 to 0x0000_0100. Expect `s_addr`/`s_wdata`/`s_wstrb` to match exactly while `grant` = 10.
- Abort: owner drops valid 1 cycle into BUSY. Expect `s_valid` low the same cycle, IDLE next cycle, no ready pulse.
- Reset mid-BUSY: assert `resetn` = 0 asynchronously. Expect `grant` = 00, `s_valid` = 0, all readys 0 without a clock edge.
- Timeout (macro on, `TIMEOUT_CYC` = 8): slave never responds. Expect `m0_ready` with `m0_rdata` = 0xDEAD_BEEF on BUSY cycle 8, then `timeout` = 1 held until reset.
